// File: rtl/multi_chan_accum_pkg.sv
// Shared types and constant helpers for the multi-channel accumulator.
// Widths are derived here so the top and its lanes agree on them.
package multi_chan_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DUMP  = 1'b1
    } state_t;

    // Widest accumulator the saturation helpers can describe.
    localparam int MAX_ACC_W = 128;

    function automatic int acc_w(input int in_w, input int guard);
        return in_w + guard;
    endfunction

    // Largest representable value of a w-bit accumulator.
    function automatic logic [MAX_ACC_W-1:0] sat_max(input int w, input bit is_signed);
        logic [MAX_ACC_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_ACC_W; i++) begin
            if (i < w - 1 || (i == w - 1 && !is_signed)) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Smallest representable value of a w-bit accumulator.
    function automatic logic [MAX_ACC_W-1:0] sat_min(input int w, input bit is_signed);
        logic [MAX_ACC_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_ACC_W; i++) begin
            if (is_signed && i == w - 1) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/accum_lane.sv
// One channel of the accumulator: wrap/saturate adder, register and sticky overflow.
// acc_next is the value the register takes at the coming edge.
module accum_lane
    import multi_chan_accum_pkg::*;
#(
    parameter int ACC_W  = 40,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ACC_W-1:0] operand,
    input  logic             add_en,
    input  logic             clr_en,
    input  logic             sat_en,
    output logic [ACC_W-1:0] acc_next,
    output logic             ovf
);

    localparam logic [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(ACC_W, SIGNED));
    localparam logic [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(ACC_W, SIGNED));

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             over;
    logic             ovf_next;

    always_comb begin
        sum = {1'b0, acc} + {1'b0, operand};
        if (SIGNED) over = (acc[ACC_W-1] == operand[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        else        over = sum[ACC_W];
    end

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_next = acc;
        ovf_next = ovf;
        if (clr_en) begin
            acc_next = '0;
            ovf_next = 1'b0;
        end else if (add_en) begin
            ovf_next = ovf | over;
            if (over && sat_en) begin
                // A signed overflow always carries the common sign of both operands.
                if (SIGNED) acc_next = acc[ACC_W-1] ? SAT_LO : SAT_HI;
                else        acc_next = SAT_HI;
            end else begin
                acc_next = sum[ACC_W-1:0];
            end
        end
    end

    // NOTE: the accumulator is state the block must report as zero after reset, so it is reset explicitly; non-blocking updates keep every lane sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            acc <= acc_next;
            ovf <= ovf_next;
        end
    end

endmodule

// File: rtl/multi_chan_accum.sv
// N-channel accumulator with ready/valid sample input and a streamed, self-clearing dump of all totals.
// Readout words are registered and held while the consumer stalls.
module multi_chan_accum
    import multi_chan_accum_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int GUARD  = 8,
    parameter int N_CH   = 4,
    parameter bit SIGNED = 1'b1,
    localparam int ACC_W = acc_w(IN_W, GUARD),
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [IN_W-1:0]  in_data,
    input  logic             sat_en,
    input  logic             clr,
    input  logic             dump_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [ACC_W-1:0] out_data,
    output logic             out_last,
    output logic [N_CH-1:0]  ovf,
    output logic             busy
);

    state_t           state;
    logic             in_hs;
    logic             out_hs;
    logic [ACC_W-1:0] operand;
    logic [N_CH-1:0]  add_en;
    logic [N_CH-1:0]  clr_en;
    logic [ACC_W-1:0] acc_next [N_CH];
    logic [CH_W-1:0]  next_ch;
    logic [CH_W-1:0]  load_ch;
    logic [ACC_W-1:0] load_data;

    assign in_ready = (state == ACCUM) && !clr;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    always_comb begin
        if (SIGNED) operand = ACC_W'($signed(in_data));
        else        operand = ACC_W'(in_data);
    end

    // Channel numbers at or above N_CH match no lane, so such samples vanish.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            add_en[i] = in_hs && (in_ch == CH_W'(i));
            clr_en[i] = ((state == ACCUM) && clr) ||
                        ((state == DUMP) && out_hs && (out_ch == CH_W'(i)));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        accum_lane #(
            .ACC_W  (ACC_W),
            .SIGNED (SIGNED)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .operand  (operand),
            .add_en   (add_en[g]),
            .clr_en   (clr_en[g]),
            .sat_en   (sat_en),
            .acc_next (acc_next[g]),
            .ovf      (ovf[g])
        );
    end

    // Entering DUMP loads channel 0 including a sample accepted in the same cycle.
    assign next_ch   = out_ch + CH_W'(1);
    assign load_ch   = (state == ACCUM) ? '0 : next_ch;
    assign load_data = acc_next[load_ch];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (dump_req) begin
                        state     <= DUMP;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_ch    <= '0;
                        out_data  <= load_data;
                        out_last  <= 1'b0;
                    end
                end
                DUMP: begin
                    if (out_hs) begin
                        if (out_last) begin
                            state     <= ACCUM;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_ch   <= next_ch;
                            out_data <= load_data;
                            out_last <= (next_ch == CH_W'(N_CH - 1));
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: doc/multi_chan_accum.md
Name: multi_chan_accum

Overview:
Parametrised N-channel accumulator with ready/valid input and output streams. Each accepted sample adds into the accumulator of the channel it targets. The adder wraps or saturates per mode, and each channel has a sticky overflow flag. A dump request streams every channel's total, then clears it. The block sits between a sample source (e.g. a MAC/filter stage) and a downstream consumer of the totals.

Parameters:
IN_W, 32, input sample width
GUARD, 8, guard bits; ACC_W = IN_W + GUARD
N_CH, 4, channel count (>=2); CH_W = $clog2(N_CH)
SIGNED, 1, 1 = two's-complement, sign-extended input; 0 = unsigned, zero-extended input

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active low
in_valid  in  1  sample valid
in_ready  out  1  block can accept a sample
in_ch  in  CH_W  target channel
in_data  in  IN_W  sample
sat_en  in  1  1 = saturate, 0 = wrap; sampled on each accepted sample
clr  in  1  clear all accumulators and flags; honoured in ACCUM only
dump_req  in  1  start readout; honoured in ACCUM only
out_valid  out  1  readout word valid
out_ready  in  1  consumer accepts word
out_ch  out  CH_W  channel of out_data
out_data  out  ACC_W  channel total
out_last  out  1  marks channel N_CH-1
ovf  out  N_CH  sticky per-channel overflow flags
busy  out  1  high in DUMP

Behaviour:
- The clock and reset are fixed: one clock, clk; the reset, rst_n, is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - state=ACCUM
  - all accumulators = 0, ovf = 0
  - out_valid = 0, out_data = 0, out_ch = 0, out_last = 0, busy = 0
  - Reset overrides everything, including mid-dump; no pending word survives.
- States: ACCUM, DUMP.
- in_ready = (state==ACCUM) && !clr. It is combinational from state and clr.
- ACCUM, sample path:
  - A handshake is in_valid && in_ready.
  - acc[in_ch] updates at that edge, so the new value is visible internally one cycle later.
  - Back-to-back samples to the same channel accumulate every cycle with no bubbles.
  - in_ch >= N_CH: sample is accepted and discarded; no state changes.
- Arithmetic:
  - Extend the input to ACC_W by sign or zero per SIGNED.
  - Sum in ACC_W+1 bits.
  - Overflow test: signed overflow when the operand signs match and the result sign differs; unsigned overflow on carry-out.
  - On overflow, ovf[ch] is set and stays set.
  - sat_en=1: clamp to the max or min of ACC_W (signed) or to all-ones (unsigned).
  - sat_en=0: keep the low ACC_W bits (wrap).
- clr in ACCUM:
  - Next cycle all accumulators and ovf are 0.
  - It blocks the handshake that cycle, because in_ready=0.
- dump_req in ACCUM:
  - State moves to DUMP next cycle.
  - A sample handshaked in the same cycle is included in the dump.
- DUMP:
  - The state is entered with out_valid=1, out_ch=0, out_data=acc[0], out_last=(N_CH==1 ? n/a : 0).
  - On each out_valid && out_ready: acc[out_ch] and ovf[out_ch] clear, and out_ch increments.
  - out_data, out_ch and out_last are registered and held stable while out_valid && !out_ready.
  - out_last=1 on channel N_CH-1. Its handshake drops out_valid and busy next cycle and returns the state to ACCUM.
  - clr, dump_req and in_valid are ignored in DUMP.
- ovf is visible for every channel at all times. It reflects a channel's flag until that channel is cleared by clr, by its dump handshake, or by reset.

Decomposition:
- Shared package multi_chan_accum_pkg:
  - state enum (ACCUM, DUMP)
  - function acc_w(in_w, guard)
  - saturation max/min constant functions
- One sub-module, accum_lane, instantiated N_CH times:
  - inputs: operand, add_en, clr_en, sat_en
  - outputs: acc value, ovf
  - holds the add/saturate logic

Test Plan:
- Defaults, reset then ch0 samples 5, 7, -3, then dump_req -> words (ch0,9), (ch1,0), (ch2,0), (ch3,0,last); ovf=0; all accumulators 0 afterwards.
- IN_W=8, GUARD=0, SIGNED=1: ch1 samples 100, 100 with sat_en=1 -> dump ch1 = 127, ovf[1]=1. Repeat with sat_en=0 -> ch1 = -56, ovf[1]=1.
- During dump, hold out_ready=0 for 3 cycles at ch2 -> out_data/out_ch stable, in_ready=0, busy=1; release -> ch3 follows next cycle.
- Same cycle: handshake ch2=4 and dump_req=1 -> dump reports ch2=4.
- clr=1 with in_valid=1 on ch0 (ch0 previously 10) -> in_ready=0, ch0 reads 0 at the next dump.
- rst_n=0 one cycle after the ch1 readout handshake -> out_valid=0 and busy=0 next cycle; next dump returns all zeros, ovf=0.
